// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl
//   Data-memory controller for the MEM stage of the pipelined MIPS core.
//   Decodes a byte address into up to four synchronous RAM regions or one
//   MMIO window. Supports byte/half/word loads and stores (big-endian),
//   with sign or zero extension of sub-word loads. Misaligned, unmapped and
//   timed-out accesses complete with err_out instead of returning zero.
//
// Ports
//   clock, reset         : clock; asynchronous active-low reset
//   req_in, we_in        : request strobe; 1 = store, 0 = load
//   addr_in              : byte address
//   writedata_in         : store data, right-justified
//   size_in, signed_in   : 00 byte / 01 half / 11 word; sign-extend loads
//   ready_out            : controller idle, request can be accepted
//   valid_out, err_out   : one-cycle completion pulse and its error flag
//   readdata_out         : load result, zero when valid_out is low
//   mmio_*_out           : registered MMIO request, held until ack/timeout
//   mmio_ack_in/rdata_in : MMIO completion and read data
module data_memory_ctrl #(
    parameter int          NUM_REGIONS  = 2,
    parameter logic [15:0] REGION0_BASE = 16'h1000,
    parameter logic [15:0] REGION1_BASE = 16'h7fff,
    parameter logic [15:0] REGION2_BASE = 16'h2000,
    parameter logic [15:0] REGION3_BASE = 16'h3000,
    parameter int          DEPTH_WORDS  = 1024,
    parameter logic [15:0] MMIO_BASE    = 16'hffff,
    parameter int          MMIO_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_in,
    input  logic        we_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] writedata_in,
    input  logic [1:0]  size_in,
    input  logic        signed_in,
    output logic        ready_out,
    output logic        valid_out,
    output logic [31:0] readdata_out,
    output logic        err_out,
    output logic        mmio_req_out,
    output logic        mmio_we_out,
    output logic [3:0]  mmio_addr_out,
    output logic [31:0] mmio_wdata_out,
    output logic [1:0]  mmio_size_out,
    input  logic        mmio_ack_in,
    input  logic [31:0] mmio_rdata_in
);
    localparam int AW  = $clog2(DEPTH_WORDS);
    localparam int MAW = $clog2(NUM_REGIONS * DEPTH_WORDS);
    localparam int CW  = $clog2(MMIO_TIMEOUT + 1);
    localparam logic [3:0][15:0] BASES = {REGION3_BASE, REGION2_BASE,
                                          REGION1_BASE, REGION0_BASE};

    typedef enum logic [1:0] {IDLE, RAM_RESP, MMIO_WAIT, ERR_RESP} state_t;

    state_t          state_q;
    logic            ready_q, valid_q, err_q, mmio_req_q, mmio_we_q;
    logic [3:0]      mmio_addr_q;
    logic [31:0]     mmio_wdata_q, rdata_q;
    logic [1:0]      mmio_size_q, size_q, off_q;
    logic            signed_q, from_mmio_q;
    logic [CW-1:0]   cnt_q;

    logic [31:0]     mem [NUM_REGIONS * DEPTH_WORDS];

    // Request decode (combinational on the live request)
    logic            accept, bad_align, mmio_hit, ram_hit, ram_we;
    logic [1:0]      region_sel;
    logic [MAW-1:0]  ram_addr;
    logic [3:0]      be;
    logic [31:0]     wlane;

    assign accept = req_in && ready_q;

    always_comb begin
        bad_align  = (size_in == 2'b10) ||
                     (size_in == 2'b01 && addr_in[0]) ||
                     (size_in == 2'b11 && addr_in[1:0] != 2'b00);
        mmio_hit   = (addr_in[31:16] == MMIO_BASE);
        ram_hit    = 1'b0;
        region_sel = 2'd0;
        // Descending scan so the lowest matching region wins
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (addr_in[31:16] == BASES[i]) begin
                ram_hit    = 1'b1;
                region_sel = 2'(i);
            end
        end
        // Big-endian lanes: byte offset 0 lives in bits 31:24
        case (size_in)
            2'b00:   begin be = 4'b1000 >> addr_in[1:0];           wlane = {4{writedata_in[7:0]}};  end
            2'b01:   begin be = addr_in[1] ? 4'b0011 : 4'b1100;    wlane = {2{writedata_in[15:0]}}; end
            default: begin be = 4'b1111;                           wlane = writedata_in;            end
        endcase
    end

    // Region index sits above the word index; the upper offset bits are dropped so regions wrap
    assign ram_addr = MAW'({region_sel, addr_in[AW+1:2]});
    assign ram_we   = accept && we_in && !bad_align && !mmio_hit && ram_hit;

    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_in[15:AW+2];

    // RAM array: no reset so contents survive a controller reset
    always_ff @(posedge clock) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[ram_addr][8*b +: 8] <= wlane[8*b +: 8];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            mmio_req_q   <= 1'b0;
            mmio_we_q    <= 1'b0;
            mmio_addr_q  <= 4'd0;
            mmio_wdata_q <= 32'd0;
            mmio_size_q  <= 2'd0;
            rdata_q      <= 32'd0;
            size_q       <= 2'd0;
            off_q        <= 2'd0;
            signed_q     <= 1'b0;
            from_mmio_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        size_q      <= size_in;
                        signed_q    <= signed_in;
                        off_q       <= addr_in[1:0];
                        from_mmio_q <= 1'b0;
                        cnt_q       <= '0;
                        ready_q     <= 1'b0;
                        if (bad_align || (!mmio_hit && !ram_hit)) begin
                            state_q <= ERR_RESP;
                            valid_q <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (mmio_hit) begin
                            state_q      <= MMIO_WAIT;
                            mmio_req_q   <= 1'b1;
                            mmio_we_q    <= we_in;
                            mmio_addr_q  <= addr_in[3:0];
                            mmio_wdata_q <= writedata_in;
                            mmio_size_q  <= size_in;
                        end else begin
                            state_q <= RAM_RESP;
                            valid_q <= 1'b1;
                            rdata_q <= mem[ram_addr];
                        end
                    end
                end
                MMIO_WAIT: begin
                    // Ack wins over expiry on the same edge
                    if (mmio_ack_in) begin
                        state_q     <= RAM_RESP;
                        rdata_q     <= mmio_rdata_in;
                        from_mmio_q <= 1'b1;
                        mmio_req_q  <= 1'b0;
                        valid_q     <= 1'b1;
                    end else if (cnt_q == CW'(MMIO_TIMEOUT - 1)) begin
                        state_q    <= ERR_RESP;
                        mmio_req_q <= 1'b0;
                        valid_q    <= 1'b1;
                        err_q      <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    // Load alignment and extension from the registered request fields
    logic [31:0] shifted, ext;
    logic [15:0] half_v;
    always_comb begin
        shifted = rdata_q >> {~off_q, 3'b000};
        half_v  = off_q[1] ? rdata_q[15:0] : rdata_q[31:16];
        case (size_q)
            2'b00:   ext = {{24{signed_q & shifted[7]}}, shifted[7:0]};
            2'b01:   ext = {{16{signed_q & half_v[15]}}, half_v};
            default: ext = rdata_q;
        endcase
    end

    assign ready_out      = ready_q;
    assign valid_out      = valid_q;
    assign err_out        = err_q;
    assign readdata_out   = (valid_q && !err_q) ? (from_mmio_q ? rdata_q : ext) : 32'd0;
    assign mmio_req_out   = mmio_req_q;
    assign mmio_we_out    = mmio_we_q;
    assign mmio_addr_out  = mmio_addr_q;
    assign mmio_wdata_out = mmio_wdata_q;
    assign mmio_size_out  = mmio_size_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl with default parameters.
module tb_data_memory_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_in = 1'b0, we_in = 1'b0, signed_in = 1'b0;
    logic [31:0] addr_in = '0, writedata_in = '0;
    logic [1:0]  size_in = '0;
    logic        ready_out, valid_out, err_out;
    logic [31:0] readdata_out;
    logic        mmio_req_out, mmio_we_out;
    logic [3:0]  mmio_addr_out;
    logic [31:0] mmio_wdata_out;
    logic [1:0]  mmio_size_out;
    logic        mmio_ack_in = 1'b0;
    logic [31:0] mmio_rdata_in = '0;

    int nvec = 0;
    int nmis = 0;

    data_memory_ctrl dut (
        .clock(clock), .reset(reset),
        .req_in(req_in), .we_in(we_in), .addr_in(addr_in),
        .writedata_in(writedata_in), .size_in(size_in), .signed_in(signed_in),
        .ready_out(ready_out), .valid_out(valid_out),
        .readdata_out(readdata_out), .err_out(err_out),
        .mmio_req_out(mmio_req_out), .mmio_we_out(mmio_we_out),
        .mmio_addr_out(mmio_addr_out), .mmio_wdata_out(mmio_wdata_out),
        .mmio_size_out(mmio_size_out), .mmio_ack_in(mmio_ack_in),
        .mmio_rdata_in(mmio_rdata_in)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic sg);
        @(negedge clock);
        req_in = 1'b1; we_in = we; addr_in = a; writedata_in = wd;
        size_in = sz; signed_in = sg;
        @(posedge clock); #1;
        req_in = 1'b0;
    endtask

    // One access; response checked one cycle after accept, then idle checked
    task automatic acc(input string tag, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] sz, input logic sg,
                       input logic exp_err, input logic chk_d, input logic [31:0] exp_d);
        drive(we, a, wd, sz, sg);
        chk({tag, ".valid"}, valid_out, 1);
        chk({tag, ".err"}, err_out, exp_err);
        if (chk_d) chk({tag, ".data"}, readdata_out, exp_d);
        @(posedge clock); #1;
        chk({tag, ".idle"}, {ready_out, valid_out}, 2'b10);
    endtask

    initial begin
        int edges;
        #12;
        chk("rst.ready", ready_out, 1);
        chk("rst.valid", valid_out, 0);
        chk("rst.err", err_out, 0);
        chk("rst.mreq", mmio_req_out, 0);
        chk("rst.rdata", readdata_out, 0);
        chk("rst.mbus", {mmio_we_out, mmio_addr_out, mmio_wdata_out, mmio_size_out}, 0);
        @(negedge clock); reset = 1'b1;

        // Word round trip
        acc("st_w",  1, 32'h10000010, 32'hDEADBEEF, 2'b11, 0, 0, 0, 0);
        acc("ld_w",  0, 32'h10000010, 32'h0,        2'b11, 0, 0, 1, 32'hDEADBEEF);

        // Byte/half lanes
        acc("st_w2", 1, 32'h10000010, 32'h11223344, 2'b11, 0, 0, 0, 0);
        acc("st_b",  1, 32'h10000013, 32'hAAAAAA80, 2'b00, 0, 0, 0, 0);
        acc("ld_sb", 0, 32'h10000013, 32'h0, 2'b00, 1, 0, 1, 32'hFFFFFF80);
        acc("ld_ub", 0, 32'h10000013, 32'h0, 2'b00, 0, 0, 1, 32'h00000080);
        acc("ld_h",  0, 32'h10000012, 32'h0, 2'b01, 0, 0, 1, 32'h00003380);
        acc("ld_sh", 0, 32'h10000010, 32'h0, 2'b01, 1, 0, 1, 32'h00001122);
        acc("ld_b0", 0, 32'h10000010, 32'h0, 2'b00, 0, 0, 1, 32'h00000011);
        acc("ld_w3", 0, 32'h10000010, 32'h0, 2'b11, 0, 0, 1, 32'h11223380);

        // Errors
        acc("e_ldw", 0, 32'h10000002, 32'h0, 2'b11, 0, 1, 1, 32'h0);
        acc("st_r1", 1, 32'h7fff0000, 32'hCAFEF00D, 2'b11, 0, 0, 0, 0);
        acc("e_sth", 1, 32'h7fff0001, 32'h0000BEEF, 2'b01, 0, 1, 1, 32'h0);
        acc("ld_r1", 0, 32'h7fff0000, 32'h0, 2'b11, 0, 0, 1, 32'hCAFEF00D);
        acc("e_unm", 1, 32'h20000000, 32'h12345678, 2'b11, 0, 1, 1, 32'h0);
        acc("e_sz",  1, 32'h10000010, 32'h0, 2'b10, 0, 1, 1, 32'h0);
        acc("e_stw", 1, 32'h10000011, 32'h0, 2'b11, 0, 1, 1, 32'h0);
        acc("ld_w4", 0, 32'h10000010, 32'h0, 2'b11, 0, 0, 1, 32'h11223380);

        // Wrap and region select
        acc("st_wr", 1, 32'h10001000, 32'h55667788, 2'b11, 0, 0, 0, 0);
        acc("ld_al", 0, 32'h10000000, 32'h0, 2'b11, 0, 0, 1, 32'h55667788);
        acc("ld_r1b",0, 32'h7fff0000, 32'h0, 2'b11, 0, 0, 1, 32'hCAFEF00D);

        // MMIO load, ack sampled on the third edge after accept
        drive(0, 32'hffff0004, 32'h0, 2'b11, 0);
        chk("mm.req", mmio_req_out, 1);
        chk("mm.addr", mmio_addr_out, 4);
        chk("mm.we", mmio_we_out, 0);
        chk("mm.size", mmio_size_out, 2'b11);
        chk("mm.busy", {ready_out, valid_out}, 2'b00);
        @(posedge clock); @(posedge clock);
        @(negedge clock); mmio_ack_in = 1'b1; mmio_rdata_in = 32'h41;
        @(posedge clock); #1;
        mmio_ack_in = 1'b0; mmio_rdata_in = 32'h0;
        chk("mm.valid", valid_out, 1);
        chk("mm.err", err_out, 0);
        chk("mm.data", readdata_out, 32'h41);
        chk("mm.reqdn", mmio_req_out, 0);
        @(posedge clock); #1;
        chk("mm.idle", {ready_out, valid_out}, 2'b10);

        // MMIO timeout
        drive(1, 32'hffff0008, 32'h99, 2'b11, 0);
        chk("to.wdata", mmio_wdata_out, 32'h99);
        edges = 40;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock); #1;
            if (valid_out) begin edges = i; break; end
        end
        chk("to.edges", edges, 15);
        chk("to.err", err_out, 1);
        chk("to.data", readdata_out, 0);
        chk("to.reqdn", mmio_req_out, 0);
        @(posedge clock); #1;
        chk("to.idle", {ready_out, valid_out}, 2'b10);

        // Async reset in MMIO_WAIT
        drive(0, 32'hffff0000, 32'h0, 2'b11, 0);
        @(posedge clock); #3;
        reset = 1'b0;
        #1;
        chk("ar.mreq", mmio_req_out, 0);
        chk("ar.ready", ready_out, 1);
        @(negedge clock); reset = 1'b1;
        acc("ar.ld1", 0, 32'h10000010, 32'h0, 2'b11, 0, 0, 1, 32'h11223380);
        acc("ar.ld2", 0, 32'h7fff0000, 32'h0, 2'b11, 0, 0, 1, 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised, handshaked data-memory controller for the pipelined MIPS core. It decodes a 32-bit address into up to four on-chip synchronous RAM regions and one memory-mapped I/O window, and supports byte, half-word and word loads and stores with sign or zero extension. Misaligned, unmapped and timed-out accesses are reported as errors instead of silently returning zero. It sits between the MEM stage and the RAM/serial blocks; the core stalls while `ready_out` is low.

## Interface
- `NUM_REGIONS`, 2: number of active RAM regions (1..4).
- `REGION0_BASE`..`REGION3_BASE`, 16'h1000, 16'h7fff, 16'h2000, 16'h3000: value of `addr_in[31:16]` that selects each region.
- `DEPTH_WORDS`, 1024: words per region (power of 2, at least 2).
- `MMIO_BASE`, 16'hffff: value of `addr_in[31:16]` that selects the MMIO window.
- `MMIO_TIMEOUT`, 15: cycles to wait for `mmio_ack_in` (at least 1).

Ports (clock and reset first):
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_in` in 1: access request.
- `we_in` in 1: 1 = store, 0 = load.
- `addr_in` in 32: byte address.
- `writedata_in` in 32: store data, right-justified.
- `size_in` in 2: 00 byte, 01 half, 11 word; 10 is illegal.
- `signed_in` in 1: sign-extend sub-word loads.
- `ready_out` out 1: controller can accept a request.
- `valid_out` out 1: one-cycle completion pulse.
- `readdata_out` out 32: load result; 0 whenever `valid_out` = 0.
- `err_out` out 1: the completing access failed; qualified by `valid_out`.
- `mmio_req_out` out 1: MMIO request, held until ack or timeout.
- `mmio_we_out` out 1: MMIO write.
- `mmio_addr_out` out 4: `addr_in[3:0]`, registered.
- `mmio_wdata_out` out 32: registered store data.
- `mmio_size_out` out 2: registered size.
- `mmio_ack_in` in 1: MMIO completion.
- `mmio_rdata_in` in 32: MMIO read data, sampled with ack.

## Operation
- **States.**
  - IDLE: `ready_out` = 1.
  - RAM_RESP: `ready_out` = 0, `valid_out` = 1.
  - MMIO_WAIT: `ready_out` = 0, `mmio_req_out` = 1.
  - ERR_RESP: `ready_out` = 0, `valid_out` = 1, `err_out` = 1.
- **Accept.** A request is accepted on a rising edge where `req_in` && `ready_out` = 1. Request fields are registered at accept.
- **Decode priority at accept.**
  1. `size_in` = 10, or misaligned (half with `addr_in[0]` = 1; word with `addr_in[1:0]` ≠ 0): go to ERR_RESP.
  2. `addr_in[31:16]` = `MMIO_BASE`: go to MMIO_WAIT.
  3. Match against REGIONi_BASE for i < `NUM_REGIONS`; the lowest matching index wins. Go to RAM_RESP.
  4. Anything else: go to ERR_RESP.
- **Side effects on error.** Erroneous accesses perform no write and no MMIO request.
- **Word index.** `addr_in[log2(DEPTH_WORDS)+1:2]`; upper offset bits are ignored, so regions wrap.
- **Byte order.** Big-endian: byte offset 0 occupies bits 31:24.
- **Stores.** Only the addressed lanes are written, at the accept edge. The byte store uses `writedata_in[7:0]`; the half store uses `writedata_in[15:0]`.
- **Loads.** The RAM is read at the accept edge. In RAM_RESP the selected byte or half is right-justified, then sign-extended if `signed_in`, otherwise zero-extended.
- **MMIO_WAIT.**
  - When `mmio_ack_in` = 1: capture `mmio_rdata_in` and go to RAM_RESP; the output mux passes MMIO data unmodified.
  - The timeout counter starts at 0 on entry. After `MMIO_TIMEOUT` cycles without ack, drop `mmio_req_out` and go to ERR_RESP.
  - An ack on the same cycle the counter expires counts as success.
- **Return to IDLE.** RAM_RESP and ERR_RESP each last exactly one cycle, then return to IDLE.
- **Reset.** Reset asserted at any time forces IDLE and drops `mmio_req_out`. RAM contents are preserved.

## Timing
- **Reset values.**
  - `ready_out` = 1.
  - `valid_out`, `err_out`, `mmio_req_out`, `mmio_we_out` = 0.
  - `readdata_out`, `mmio_addr_out`, `mmio_wdata_out`, `mmio_size_out` = 0.
- **RAM access.** Accept at edge T; `valid_out` is high during cycle T+1. This gives one access per 2 cycles.
- **Error access.** Same latency as a RAM access.
- **MMIO access.** `mmio_req_out` rises after the accept edge. With ack sampled at edge T+k, `valid_out` is high in cycle T+k+1. On timeout, `valid_out` is high `MMIO_TIMEOUT`+1 cycles after accept.
- **Held inputs.** `req_in` held high while `ready_out` = 0 is ignored; it is not queued.
- **Stray acks.** `mmio_ack_in` outside MMIO_WAIT is ignored.

## Test plan
- **Word round-trip.** Store word 0xDEADBEEF to 0x10000010, then load word from 0x10000010 → `valid_out` one cycle after each accept; load returns 0xDEADBEEF with `err_out` = 0.
- **Byte/half lanes.** Store byte 0x80 to 0x10000013 over 0x11223344, then:
  - signed byte load from 0x10000013 → 0xFFFFFF80;
  - unsigned byte load from 0x10000013 → 0x00000080;
  - half load from 0x10000012 → 0x00003380.
- **Errors.** Each of the following gives `err_out` = 1 and `readdata_out` = 0, and the location is unchanged on a later read:
  - word load at 0x10000002;
  - half store at 0x7fff0001;
  - any access to 0x20000000 with `NUM_REGIONS` = 2.
- **Wrap and region select.** With `DEPTH_WORDS` = 1024, a store to 0x10001000 aliases 0x10000000, and 0x7fff0000 is independent.
- **MMIO.**
  - Load 0xffff0004 with ack after 3 cycles, `mmio_rdata_in` = 0x41 → `mmio_addr_out` = 4, result 0x41.
  - With no ack → `err_out` after 15 cycles.
- **Async reset.** Assert reset during MMIO_WAIT → `mmio_req_out` = 0 immediately, `ready_out` = 1; RAM data written earlier is intact.
